// File: rtl/sb_pkg.sv
// Shared types and constants for the switch-box configuration loader.
package sb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FULL   = 2'd2,
        ST_COMMIT = 2'd3
    } ld_state_e;

    localparam int SB_BITS_PER_TRACK = 8;
    localparam int SEL_W             = 2;

    localparam int OFS_N = 0;
    localparam int OFS_E = 2;
    localparam int OFS_S = 4;
    localparam int OFS_W = 6;

    function automatic int num_words(input int cfg_size, input int word_w);
        return cfg_size / word_w;
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sb_cfg_loader.sv
// Streams switch-box config words into a shadow register and applies
// the complete image atomically to the live cfg bus on commit.
module sb_cfg_loader
    import sb_pkg::*;
#(
    parameter int CHN_WIDTH = 16,
    parameter int CFG_SIZE  = CHN_WIDTH * SB_BITS_PER_TRACK,
    parameter int WORD_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                commit,
    output logic [CFG_SIZE-1:0] cfg,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int NUM_WORDS = num_words(CFG_SIZE, WORD_W);
    localparam int IDX_W     = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    ld_state_e            state;
    ld_state_e            nxt;
    logic [IDX_W-1:0]     idx;
    logic [CFG_SIZE-1:0]  shadow;
    logic                 ld_clr;
    logic                 ld_we;
    logic                 set_err;
    logic                 apply;

    // Outputs depend only on the state register, never on in_valid.
    assign in_ready = (state == ST_LOAD);
    assign busy     = (state == ST_LOAD) || (state == ST_FULL);

    always_comb begin
        nxt     = state;
        ld_clr  = 1'b0;
        ld_we   = 1'b0;
        set_err = 1'b0;
        apply   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    nxt    = ST_LOAD;
                    ld_clr = 1'b1;
                end else if (commit) begin
                    set_err = 1'b1;
                end
            end
            ST_LOAD: begin
                if (start) begin
                    ld_clr = 1'b1;
                end else begin
                    set_err = commit;
                    if (in_valid) begin
                        ld_we = 1'b1;
                        if (idx == LAST_IDX) nxt = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (start) begin
                    nxt    = ST_LOAD;
                    ld_clr = 1'b1;
                end else if (commit) begin
                    nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                apply = 1'b1;
                nxt   = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            shadow <= '0;
            cfg    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= nxt;
            done  <= apply;
            if (ld_clr) begin
                idx    <= '0;
                shadow <= '0;
                err    <= 1'b0;
            end else if (ld_we) begin
                shadow[int'(idx)*WORD_W +: WORD_W] <= in_data;
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            if (set_err) err <= 1'b1;
            if (apply)   cfg <= shadow;
        end
    end

endmodule
